// File: rtl/tmp_dec_pkg.sv
// Shared types and constants for the temperature sigma-delta decimator.
// Result width and synchronizer depth are defined here so every file agrees on them.
package tmp_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2
  } state_t;

  localparam int SYNC_DEPTH = 2;

  // Wide enough for the ramp-weighted sum N*(N+1)/2 of the second integrator.
  function automatic int res_w(input int osr_log2);
    return 2 * osr_log2 + 1;
  endfunction

endpackage

// File: rtl/tmp_dec_sync.sv
// Multi-flop synchronizer that brings the asynchronous comparator output into clk.
// Every stage is cleared while reset is low.
module tmp_dec_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/tmp_sd_decimator.sv
// Comparator decimator: counts ones over 2**OSR_LOG2 samples per window, one result per window.
// Define TMP_DEC_SINC2_EN to add a second integrator (ramp-weighted result).
module tmp_sd_decimator
  import tmp_dec_pkg::*;
#(
  parameter  int OSR_LOG2    = 8,
  parameter  int SETTLE_SMPL = 4,
  localparam int RES_W       = res_w(OSR_LOG2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmp,
  input  logic             cmp_strobe,
  input  logic             conv_en,
  input  logic             res_ready,
  output logic [RES_W-1:0] result,
  output logic             res_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int                  CW          = OSR_LOG2 + 1;
  localparam logic [OSR_LOG2-1:0] SMP_LAST    = '1;
  localparam logic [3:0]          SETTLE_LAST = 4'((SETTLE_SMPL > 0) ? SETTLE_SMPL - 1 : 0);

  state_t              state, state_nxt;
  logic                cmp_s;
  logic [SYNC_DEPTH-1:0] strobe_d;
  logic                sample;
  logic [3:0]          settle_cnt;
  logic [OSR_LOG2-1:0] smp_cnt;
  logic [CW-1:0]       acc1, acc1_nxt;
  logic [RES_W-1:0]    win_val;
  logic                win_done;

  tmp_dec_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cmp),
    .q     (cmp_s)
  );

  // Strobe delayed by the synchronizer depth so it lines up with cmp_s.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) strobe_d <= '0;
    else        strobe_d <= {strobe_d[SYNC_DEPTH-2:0], cmp_strobe};
  end

  assign sample   = strobe_d[SYNC_DEPTH-1] & conv_en;
  assign acc1_nxt = acc1 + CW'(cmp_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (conv_en) state_nxt = (SETTLE_SMPL == 0) ? ACCUM : SETTLE;
      end
      SETTLE: begin
        if (!conv_en)                                state_nxt = IDLE;
        else if (sample && settle_cnt == SETTLE_LAST) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (!conv_en)                            state_nxt = IDLE;
        else if (sample && smp_cnt == SMP_LAST) win_done  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= '0;
    end else if (state == SETTLE && state_nxt == SETTLE) begin
      if (sample) settle_cnt <= settle_cnt + 4'd1;
    end else begin
      settle_cnt <= '0;
    end
  end

  // A partial window is discarded whenever ACCUM is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_cnt <= '0;
      acc1    <= '0;
    end else if (state == ACCUM && conv_en) begin
      if (win_done) begin
        smp_cnt <= '0;
        acc1    <= '0;
      end else if (sample) begin
        smp_cnt <= smp_cnt + OSR_LOG2'(1);
        acc1    <= acc1_nxt;
      end
    end else begin
      smp_cnt <= '0;
      acc1    <= '0;
    end
  end

`ifdef TMP_DEC_SINC2_EN
  logic [RES_W-1:0] acc2, acc2_nxt;

  assign acc2_nxt = acc2 + RES_W'(acc1_nxt);
  assign win_val  = acc2_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc2 <= '0;
    end else if (state == ACCUM && conv_en) begin
      if (win_done)    acc2 <= '0;
      else if (sample) acc2 <= acc2_nxt;
    end else begin
      acc2 <= '0;
    end
  end
`else
  assign win_val = RES_W'(acc1_nxt);
`endif

  // Handshake: a result transfers on any cycle where res_valid && res_ready;
  // result is held stable while res_valid is high, and a completing window
  // always wins over the transfer so no result is lost in that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (win_done) begin
        result    <= win_val;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (win_done && res_valid && !res_ready) overrun <= 1'b1;
      else if (res_valid && res_ready)         overrun <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tmp_sd_decimator.sv
// Randomized bench for tmp_sd_decimator (OSR_LOG2=4, SETTLE_SMPL=2, strobe every 4 clk).
// Expected window results come from a weighted-sum model of the sample bits.
`timescale 1ns/1ps
module tb_tmp_sd_decimator;

  localparam int N     = 16;
  localparam int RES_W = 9;

  logic             clk;
  logic             reset;
  logic             cmp;
  logic             cmp_strobe;
  logic             conv_en;
  logic             res_ready;
  logic [RES_W-1:0] result;
  logic             res_valid;
  logic             overrun;
  logic             busy;

  int total;
  int bad;

  tmp_sd_decimator #(.OSR_LOG2(4), .SETTLE_SMPL(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmp        (cmp),
    .cmp_strobe (cmp_strobe),
    .conv_en    (conv_en),
    .res_ready  (res_ready),
    .result     (result),
    .res_valid  (res_valid),
    .overrun    (overrun),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: plain count of ones, or each one weighted by how many
  // integration steps remain in the window for the second integrator
  function automatic logic [RES_W-1:0] model(input logic [N-1:0] b);
    int ones;
    int ramp;
    ones = 0;
    ramp = 0;
    for (int i = 0; i < N; i++) begin
      ones += int'(b[i]);
      ramp += int'(b[i]) * (N - i);
    end
`ifdef TMP_DEC_SINC2_EN
    return RES_W'(ramp);
`else
    return RES_W'(ones);
`endif
  endfunction

  // driver tasks; called at #1 after a rising edge, return at #1 after a rising edge
  task automatic send_sample(input bit v, input bit pulse_ready, output bit a2, output bit a3,
                             output logic [RES_W-1:0] r, output bit o);
    cmp        = v;
    cmp_strobe = 1'b1;
    @(posedge clk); #1;
    cmp_strobe = 1'b0;
    @(posedge clk); #1;
    a2 = res_valid;
    if (pulse_ready) res_ready = 1'b1;
    @(posedge clk); #1;
    a3 = res_valid;
    r  = result;
    o  = overrun;
    if (pulse_ready) res_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_idle_strobes(input int n);
    bit a2, a3, o;
    logic [RES_W-1:0] r;
    for (int i = 0; i < n; i++) send_sample(1'($urandom_range(0, 1)), 1'b0, a2, a3, r, o);
  endtask

  task automatic run_window(input int n_settle, input logic [N-1:0] b, input bit pulse_last,
                            output bit early, output bit v2, output bit v3,
                            output logic [RES_W-1:0] r3, output bit ov3);
    bit a2, a3, o;
    logic [RES_W-1:0] r;
    early = 1'b0;
    for (int i = 0; i < n_settle; i++) begin
      send_sample(1'($urandom_range(0, 1)), 1'b0, a2, a3, r, o);
      early |= a3;
    end
    for (int i = 0; i < N; i++) begin
      send_sample(b[i], pulse_last && (i == N - 1), a2, a3, r, o);
      if (i < N - 1) early |= a3;
      else begin
        v2  = a2;
        v3  = a3;
        r3  = r;
        ov3 = o;
      end
    end
  endtask

  task automatic start_conv();
    conv_en = 1'b0;
    @(posedge clk); #1;
    conv_en = 1'b1;
    @(posedge clk); #1;
  endtask

  // tests
  task automatic test_reset();
    #1;
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones();
    bit early, v2, v3, ov3;
    logic [RES_W-1:0] r3;
    res_ready = 1'b1;
    start_conv();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ones_busy: got %b want 1", busy); end
    for (int w = 0; w < 2; w++) begin
      run_window((w == 0) ? 2 : 0, '1, 1'b0, early, v2, v3, r3, ov3);
      total++; if (early !== 1'b0) begin bad++; $display("FAIL ones_early_w%0d: got %b want 0", w, early); end
      total++; if (v2 !== 1'b0) begin bad++; $display("FAIL ones_latency_pre_w%0d: got %b want 0", w, v2); end
      total++; if (v3 !== 1'b1) begin bad++; $display("FAIL ones_valid_w%0d: got %b want 1", w, v3); end
      total++; if (r3 !== model('1)) begin bad++; $display("FAIL ones_result_w%0d: got %0d want %0d", w, r3, model('1)); end
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ones_valid_one_cycle: got %b want 0", res_valid); end
  endtask

  task automatic test_patterns();
    bit early, v2, v3, ov3;
    logic [RES_W-1:0] r3;
    logic [N-1:0] b;
    for (int w = 0; w < 5; w++) begin
      b = (w == 0) ? 16'h5555 : 16'($urandom());
      run_window(0, b, 1'b0, early, v2, v3, r3, ov3);
      total++; if (early !== 1'b0) begin bad++; $display("FAIL pat_early_w%0d: got %b want 0", w, early); end
      total++; if (v3 !== 1'b1) begin bad++; $display("FAIL pat_valid_w%0d: got %b want 1", w, v3); end
      total++; if (r3 !== model(b)) begin bad++; $display("FAIL pat_result_w%0d: got %0d want %0d (bits %h)", w, r3, model(b), b); end
    end
  endtask

  task automatic test_abort();
    bit a2, a3, o, early, v2, v3, ov3;
    logic [RES_W-1:0] r, r3, held;
    logic [N-1:0] b;
    held = result;
    start_conv();
    for (int i = 0; i < 2 + 10; i++) send_sample(1'b1, 1'b0, a2, a3, r, o);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    conv_en = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after: got %b want 0", busy); end
    send_idle_strobes(3);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result: got %b want 0", res_valid); end
    total++; if (result !== held) begin bad++; $display("FAIL abort_result_held: got %0d want %0d", result, held); end
    b = 16'($urandom());
    start_conv();
    run_window(2, b, 1'b0, early, v2, v3, r3, ov3);
    total++; if (early !== 1'b0) begin bad++; $display("FAIL abort_resettle_early: got %b want 0", early); end
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL abort_resettle_valid: got %b want 1", v3); end
    total++; if (r3 !== model(b)) begin bad++; $display("FAIL abort_resettle_result: got %0d want %0d", r3, model(b)); end
  endtask

  task automatic test_overrun();
    bit early, v2, v3, ov3;
    logic [RES_W-1:0] r3;
    logic [N-1:0] b1, b2;
    b1 = 16'($urandom());
    b2 = ~b1;
    res_ready = 1'b0;
    start_conv();
    run_window(2, b1, 1'b0, early, v2, v3, r3, ov3);
    total++; if (r3 !== model(b1)) begin bad++; $display("FAIL ovr_first_result: got %0d want %0d", r3, model(b1)); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL ovr_first_flag: got %b want 0", ov3); end
    run_window(0, b2, 1'b0, early, v2, v3, r3, ov3);
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL ovr_second_valid: got %b want 1", v3); end
    total++; if (r3 !== model(b2)) begin bad++; $display("FAIL ovr_second_result: got %0d want %0d", r3, model(b2)); end
    total++; if (ov3 !== 1'b1) begin bad++; $display("FAIL ovr_flag_set: got %b want 1", ov3); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain_valid: got %b want 0", res_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_flag_clear: got %b want 0", overrun); end
    conv_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit early, v2, v3, ov3;
    logic [RES_W-1:0] r3;
    logic [N-1:0] b1, b2;
    b1 = 16'($urandom());
    b2 = 16'($urandom()) ^ 16'h0001;
    res_ready = 1'b0;
    start_conv();
    run_window(2, b1, 1'b0, early, v2, v3, r3, ov3);
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL b2b_first_valid: got %b want 1", v3); end
    run_window(0, b2, 1'b1, early, v2, v3, r3, ov3);
    total++; if (v2 !== 1'b1) begin bad++; $display("FAIL b2b_held_valid: got %b want 1", v2); end
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL b2b_valid_stays: got %b want 1", v3); end
    total++; if (r3 !== model(b2)) begin bad++; $display("FAIL b2b_new_result: got %0d want %0d", r3, model(b2)); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun: got %b want 0", ov3); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", res_valid); end
    conv_en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit a2, a3, o, early, v2, v3, ov3;
    logic [RES_W-1:0] r, r3;
    logic [N-1:0] b;
    res_ready = 1'b0;
    start_conv();
    run_window(2, 16'($urandom()) | 16'h0001, 1'b0, early, v2, v3, r3, ov3);
    run_window(0, 16'($urandom()) | 16'h0001, 1'b0, early, v2, v3, r3, ov3);
    for (int i = 0; i < 5; i++) send_sample(1'b1, 1'b0, a2, a3, r, o);
    total++; if (res_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL arst_precond: got valid=%b ovr=%b busy=%b want 1 1 1", res_valid, overrun, busy);
    end
    #2 reset = 1'b0;
    #1;
    total++; if (result !== '0) begin bad++; $display("FAIL arst_result: got %0d want 0", result); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", res_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL arst_overrun: got %b want 0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    conv_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_idle_strobes(4);
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL arst_idle_strobes: got busy=%b valid=%b want 0 0", busy, res_valid);
    end
    res_ready = 1'b1;
    b = 16'($urandom());
    start_conv();
    run_window(2, b, 1'b0, early, v2, v3, r3, ov3);
    total++; if (early !== 1'b0) begin bad++; $display("FAIL arst_after_early: got %b want 0", early); end
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL arst_after_valid: got %b want 1", v3); end
    total++; if (r3 !== model(b)) begin bad++; $display("FAIL arst_after_result: got %0d want %0d", r3, model(b)); end
    conv_en = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    cmp        = 1'b0;
    cmp_strobe = 1'b0;
    conv_en    = 1'b0;
    res_ready  = 1'b0;
    test_reset();
    test_all_ones();
    test_patterns();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
